// File: rtl/defs.sv
// Shared definitions for the LL/SC reservation slice: decoded op encodings
// and the opcode-byte constants used by the decoder.
package defs_pkg;

  typedef enum logic [1:0] {
    ATOMIC_LL     = 2'b00,
    ATOMIC_SC     = 2'b01,
    INVALID_OP_2B = 2'b11
  } llsc_op_e;

  // Word and double-word flavours of LL/SC, keyed on instr[31:24]
  localparam logic [7:0] OPC_LL_W = 8'h20;
  localparam logic [7:0] OPC_SC_W = 8'h21;
  localparam logic [7:0] OPC_LL_D = 8'h22;
  localparam logic [7:0] OPC_SC_D = 8'h23;

endpackage

// File: rtl/llsc_reservation_unit_decode.sv
// Combinational LL/SC opcode decoder; only the top opcode byte is significant.
module llsc_decode
  import defs_pkg::*;
(
  input  logic [31:0] instr,
  output llsc_op_e    op
);

  logic unused_instr_low;
  assign unused_instr_low = ^instr[23:0];

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    op = INVALID_OP_2B;
    case (instr[31:24])
      OPC_LL_W, OPC_LL_D: op = ATOMIC_LL;
      OPC_SC_W, OPC_SC_D: op = ATOMIC_SC;
      default:            op = INVALID_OP_2B;
    endcase
  end

endmodule

// File: rtl/llsc_reservation_unit.sv
// Per-thread LL/SC reservation tracker with a single registered response slot.
// Optional reservation lifetime counters are enabled by defining LLSC_TIMEOUT_EN.
module llsc_reservation_unit
  import defs_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int NTHR      = 2,
  parameter  int GRAN_LOG2 = 3,
  parameter  int TIMEOUT   = 255,
  localparam int TW        = (NTHR > 1) ? $clog2(NTHR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_instr,
  input  logic [TW-1:0]     req_tid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [TW-1:0]     resp_tid,
  output logic [1:0]        resp_op,
  output logic              resp_sc_ok,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              flush_valid,
  input  logic [TW-1:0]     flush_tid,
  output logic [NTHR-1:0]   rsv_valid
);

  localparam int GW = ADDR_W - GRAN_LOG2;

  llsc_op_e            dec_op, req_op;
  logic                accept, tid_ok, sc_ok;
  logic [GW-1:0]       req_gran, snoop_gran;
  logic [NTHR-1:0]     rsv_valid_q, rsv_valid_d;
  logic [GW-1:0]       rsv_gran_q [NTHR];
  logic [GW-1:0]       rsv_gran_d [NTHR];
  logic [NTHR-1:0]     ll_hit, sc_hit, flush_hit, snoop_hit, expired;

  logic                resp_valid_q;
  logic [TW-1:0]       resp_tid_q;
  llsc_op_e            resp_op_q;
  logic                resp_sc_ok_q;

  logic unused_addr_low;
  assign unused_addr_low = ^{req_addr[GRAN_LOG2-1:0], snoop_addr[GRAN_LOG2-1:0]};

  llsc_decode u_decode (
    .instr (req_instr),
    .op    (dec_op)
  );

  assign req_ready  = !resp_valid_q || resp_ready;
  assign accept     = req_valid && req_ready;
  assign tid_ok     = 32'(req_tid) < NTHR;
  assign req_op     = tid_ok ? dec_op : INVALID_OP_2B;
  assign req_gran   = req_addr[ADDR_W-1:GRAN_LOG2];
  assign snoop_gran = snoop_addr[ADDR_W-1:GRAN_LOG2];

  // Same-cycle snoop or flush is ordered ahead of the SC and defeats it
  always_comb begin
    sc_ok = 1'b0;
    if (req_op == ATOMIC_SC) begin
      sc_ok = rsv_valid_q[req_tid] && (rsv_gran_q[req_tid] == req_gran)
           && !(snoop_valid && (snoop_gran == req_gran))
           && !(flush_valid && (flush_tid == req_tid));
    end
  end

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      ll_hit[i]      = accept && (req_op == ATOMIC_LL) && (req_tid == TW'(i));
      sc_hit[i]      = accept && (req_op == ATOMIC_SC) && (req_tid == TW'(i));
      flush_hit[i]   = flush_valid && (flush_tid == TW'(i));
      snoop_hit[i]   = snoop_valid && (rsv_gran_q[i] == snoop_gran);
      rsv_valid_d[i] = rsv_valid_q[i] && !snoop_hit[i] && !expired[i] && !sc_hit[i];
      rsv_gran_d[i]  = rsv_gran_q[i];
      // LL beats a same-cycle snoop, flush beats the LL
      if (ll_hit[i]) begin
        rsv_valid_d[i] = 1'b1;
        rsv_gran_d[i]  = req_gran;
      end
      if (flush_hit[i]) rsv_valid_d[i] = 1'b0;
    end
  end

`ifdef LLSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q [NTHR];
  logic [CW-1:0] cnt_d [NTHR];

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      expired[i] = rsv_valid_q[i] && (cnt_q[i] == CW'(TIMEOUT));
      cnt_d[i]   = cnt_q[i];
      if (ll_hit[i])                         cnt_d[i] = '0;
      else if (rsv_valid_q[i] && !expired[i]) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHR; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NTHR; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired = '0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_valid_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_tid_q    <= '0;
      resp_op_q     <= INVALID_OP_2B;
      resp_sc_ok_q  <= 1'b0;
    end else begin
      rsv_valid_q <= rsv_valid_d;
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_tid_q   <= req_tid;
        resp_op_q    <= req_op;
        resp_sc_ok_q <= sc_ok;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: granule storage is qualified by rsv_valid_q, so it needs no reset and stays plain storage.
  always_ff @(posedge clk) begin
    rsv_gran_q <= rsv_gran_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_tid   = resp_tid_q;
  assign resp_op    = resp_op_q;
  assign resp_sc_ok = resp_sc_ok_q;
  assign rsv_valid  = rsv_valid_q;

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-level reservation model.
module tb_llsc_reservation_unit;
  import defs_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int NTHR      = 2;
  localparam int GRAN_LOG2 = 3;
  localparam int TIMEOUT   = 4;
  localparam int TW        = 1;

  localparam logic [1:0] OP_LL  = 2'(ATOMIC_LL);
  localparam logic [1:0] OP_SC  = 2'(ATOMIC_SC);
  localparam logic [1:0] OP_INV = 2'(INVALID_OP_2B);

  logic              clk, rst_n;
  logic              req_valid, req_ready;
  logic [31:0]       req_instr;
  logic [TW-1:0]     req_tid;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid, resp_ready;
  logic [TW-1:0]     resp_tid;
  logic [1:0]        resp_op;
  logic              resp_sc_ok;
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic              flush_valid;
  logic [TW-1:0]     flush_tid;
  logic [NTHR-1:0]   rsv_valid;

  llsc_reservation_unit #(
    .ADDR_W(ADDR_W), .NTHR(NTHR), .GRAN_LOG2(GRAN_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_tid(req_tid), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tid(resp_tid),
    .resp_op(resp_op), .resp_sc_ok(resp_sc_ok),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .flush_valid(flush_valid), .flush_tid(flush_tid),
    .rsv_valid(rsv_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            rv;
    logic [31:0]     instr;
    logic [TW-1:0]   tid;
    logic [31:0]     addr;
    logic            rr;
    logic            sv;
    logic [31:0]     sa;
    logic            fv;
    logic [TW-1:0]   ft;
    logic            e_ready;
    logic            e_rv;
    logic [1:0]      e_op;
    logic            e_ok;
    logic [NTHR-1:0] e_rsv;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [7:0] opc, input logic [TW-1:0] tid,
                              input logic [31:0] addr, input logic sv, input logic [31:0] sa,
                              input logic fv, input logic [TW-1:0] ft, input logic e_rv,
                              input logic [1:0] e_op, input logic e_ok, input logic [NTHR-1:0] e_rsv);
    vec_t v;
    v.rv = rv; v.instr = {opc, 24'h00_1234}; v.tid = tid; v.addr = addr; v.rr = 1'b1;
    v.sv = sv; v.sa = sa; v.fv = fv; v.ft = ft;
    v.e_ready = 1'b1; v.e_rv = e_rv; v.e_op = e_op; v.e_ok = e_ok; v.e_rsv = e_rsv;
    return v;
  endfunction

  task automatic drive_idle();
    req_valid = 1'b0; req_instr = '0; req_tid = '0; req_addr = '0;
    resp_ready = 1'b1; snoop_valid = 1'b0; snoop_addr = '0;
    flush_valid = 1'b0; flush_tid = '0;
  endtask

  task automatic drive_req(input logic [7:0] opc, input logic [TW-1:0] tid, input logic [31:0] addr);
    req_valid = 1'b1; req_instr = {opc, 24'h0}; req_tid = tid; req_addr = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference model
  bit          m_rsv   [NTHR];
  int unsigned m_gran  [NTHR];
  int          m_stamp [NTHR];
  int          m_edge;
  bit          e_rv, e_ok;
  logic [TW-1:0] e_tid;
  logic [1:0]  e_op;

  task automatic model_reset();
    for (int i = 0; i < NTHR; i++) begin m_rsv[i] = 0; m_gran[i] = 0; m_stamp[i] = 0; end
    m_edge = 0; e_rv = 0; e_ok = 0; e_tid = '0; e_op = OP_INV;
  endtask

  task automatic model_edge(input bit ready);
    bit acc, ok;
    logic [1:0] op;
    int unsigned g, sg;
    int t;
    acc = req_valid && ready;
    t   = int'(req_tid);
    g   = req_addr >> GRAN_LOG2;
    sg  = snoop_addr >> GRAN_LOG2;
    op  = OP_INV;
    if (t < NTHR) begin
      if (req_instr[31:24] == 8'h20 || req_instr[31:24] == 8'h22) op = OP_LL;
      if (req_instr[31:24] == 8'h21 || req_instr[31:24] == 8'h23) op = OP_SC;
    end
    ok = (op == OP_SC) && m_rsv[t] && (m_gran[t] == g)
      && !(snoop_valid && sg == g) && !(flush_valid && int'(flush_tid) == t);
    m_edge++;
    for (int i = 0; i < NTHR; i++) begin
`ifdef LLSC_TIMEOUT_EN
      if (m_rsv[i] && m_edge > m_stamp[i] + TIMEOUT) m_rsv[i] = 0;
`endif
      if (snoop_valid && m_gran[i] == sg) m_rsv[i] = 0;
      if (acc && op == OP_LL && t == i) begin m_rsv[i] = 1; m_gran[i] = g; m_stamp[i] = m_edge; end
      if (acc && op == OP_SC && t == i) m_rsv[i] = 0;
      if (flush_valid && int'(flush_tid) == i) m_rsv[i] = 0;
    end
    if (acc) begin e_rv = 1; e_tid = req_tid; e_op = op; e_ok = ok; end
    else if (resp_ready) e_rv = 0;
  endtask

  function automatic logic [NTHR-1:0] model_rsv_vec();
    logic [NTHR-1:0] v;
    for (int i = 0; i < NTHR; i++) v[i] = m_rsv[i];
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] opc_pool [6];
    bit m_ready;

    drive_idle();
    rst_n = 1'b0;
    #12;
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset rsv_valid", rsv_valid, '0);
    check("reset resp_op", resp_op, OP_INV);
    check("reset resp_tid", resp_tid, '0);
    check("reset resp_sc_ok", resp_sc_ok, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    //          rv opc    tid addr       sv  saddr      fv ft  e_rv e_op   ok  rsv
    tbl.push_back(mk(1, 8'h20, 0, 32'h1000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h21, 0, 32'h1004, 0, 32'h0,    0, 0, 1, OP_SC,  1, 2'b00));
    tbl.push_back(mk(1, 8'h22, 1, 32'h2000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b10));
    tbl.push_back(mk(1, 8'h20, 0, 32'h5000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b11));
    tbl.push_back(mk(0, 8'h00, 0, 32'h0,    1, 32'h2007, 0, 0, 0, OP_INV, 0, 2'b01));
    tbl.push_back(mk(1, 8'h23, 1, 32'h2000, 0, 32'h0,    0, 0, 1, OP_SC,  0, 2'b01));
    tbl.push_back(mk(1, 8'h20, 0, 32'h3000, 1, 32'h3000, 0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h20, 0, 32'h3000, 0, 32'h0,    1, 0, 1, OP_LL,  0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 1, 32'h4000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b10));
    tbl.push_back(mk(1, 8'h28, 1, 32'h4000, 0, 32'h0,    0, 0, 1, OP_INV, 0, 2'b10));
    tbl.push_back(mk(1, 8'h21, 0, 32'h4000, 0, 32'h0,    0, 0, 1, OP_SC,  0, 2'b10));
    tbl.push_back(mk(1, 8'h21, 1, 32'h4008, 0, 32'h0,    0, 0, 1, OP_SC,  0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 1, 32'h4000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b10));
    tbl.push_back(mk(1, 8'h21, 1, 32'h4000, 0, 32'h0,    1, 1, 1, OP_SC,  0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 0, 32'h6000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h21, 0, 32'h6000, 1, 32'h6003, 0, 0, 1, OP_SC,  0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 0, 32'h7000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h22, 0, 32'h7100, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h21, 0, 32'h7000, 0, 32'h0,    0, 0, 1, OP_SC,  0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 0, 32'h7100, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h23, 0, 32'h7104, 0, 32'h0,    0, 0, 1, OP_SC,  1, 2'b00));
    tbl.push_back(mk(1, 8'h20, 1, 32'h8000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b10));
    tbl.push_back(mk(0, 8'h00, 0, 32'h0,    0, 32'h0,    1, 0, 0, OP_INV, 0, 2'b10));
    tbl.push_back(mk(0, 8'h00, 0, 32'h0,    0, 32'h0,    1, 1, 0, OP_INV, 0, 2'b00));
    tbl.push_back(mk(1, 8'h20, 0, 32'hA000, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b01));
    tbl.push_back(mk(1, 8'h20, 1, 32'hA004, 0, 32'h0,    0, 0, 1, OP_LL,  0, 2'b11));
    tbl.push_back(mk(0, 8'h00, 0, 32'h0,    1, 32'hA006, 0, 0, 0, OP_INV, 0, 2'b00));

    foreach (tbl[k]) begin
      req_valid = tbl[k].rv; req_instr = tbl[k].instr; req_tid = tbl[k].tid; req_addr = tbl[k].addr;
      resp_ready = tbl[k].rr; snoop_valid = tbl[k].sv; snoop_addr = tbl[k].sa;
      flush_valid = tbl[k].fv; flush_tid = tbl[k].ft;
      #1;
      check($sformatf("vec%0d req_ready", k), req_ready, tbl[k].e_ready);
      tick();
      check($sformatf("vec%0d resp_valid", k), resp_valid, tbl[k].e_rv);
      if (tbl[k].e_rv) begin
        check($sformatf("vec%0d resp_op", k), resp_op, tbl[k].e_op);
        check($sformatf("vec%0d resp_tid", k), resp_tid, tbl[k].tid);
        check($sformatf("vec%0d resp_sc_ok", k), resp_sc_ok, tbl[k].e_ok);
      end
      check($sformatf("vec%0d rsv_valid", k), rsv_valid, tbl[k].e_rsv);
    end
    drive_idle();
    tick();

    // Back-pressure: response held for three cycles, then handshake with a new accept
    drive_req(8'h20, 1, 32'h8800);
    resp_ready = 1'b0;
    tick();
    check("stall first resp_valid", resp_valid, 1'b1);
    drive_req(8'h21, 1, 32'h8804);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d req_ready", c), req_ready, 1'b0);
      tick();
      check($sformatf("stall%0d resp_valid", c), resp_valid, 1'b1);
      check($sformatf("stall%0d resp_op", c), resp_op, OP_LL);
      check($sformatf("stall%0d resp_tid", c), resp_tid, 1'b1);
      check($sformatf("stall%0d resp_sc_ok", c), resp_sc_ok, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    check("stall release req_ready", req_ready, 1'b1);
    tick();
    check("stall second resp_valid", resp_valid, 1'b1);
    check("stall second resp_op", resp_op, OP_SC);
    check("stall second resp_sc_ok", resp_sc_ok, 1'b1);
    drive_idle();
    tick();
    check("stall drain resp_valid", resp_valid, 1'b0);

    // Reservation lifetime: expires after TIMEOUT idle cycles only when enabled
    drive_req(8'h20, 0, 32'h9000);
    tick();
    drive_idle();
    for (int j = 1; j <= 6; j++) begin
      tick();
`ifdef LLSC_TIMEOUT_EN
      check($sformatf("timeout idle%0d rsv0", j), rsv_valid[0], (j <= TIMEOUT) ? 1'b1 : 1'b0);
`else
      check($sformatf("timeout idle%0d rsv0", j), rsv_valid[0], 1'b1);
`endif
    end
    drive_req(8'h21, 0, 32'h9000);
    tick();
`ifdef LLSC_TIMEOUT_EN
    check("timeout sc_ok", resp_sc_ok, 1'b0);
`else
    check("timeout sc_ok", resp_sc_ok, 1'b1);
`endif
    drive_idle();
    tick();

    // Asynchronous reset mid-response
    drive_req(8'h20, 0, 32'hB000);
    resp_ready = 1'b0;
    tick();
    check("pre-reset resp_valid", resp_valid, 1'b1);
    check("pre-reset rsv_valid", rsv_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("async reset resp_valid", resp_valid, 1'b0);
    check("async reset rsv_valid", rsv_valid, '0);
    check("async reset resp_op", resp_op, OP_INV);
    check("async reset resp_sc_ok", resp_sc_ok, 1'b0);
    #1 rst_n = 1'b1;
    check("post-reset req_ready", req_ready, 1'b1);
    drive_idle();
    tick();
    model_reset();

    // Randomized traffic against the reference model
    opc_pool = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h28, 8'h00};
    for (int n = 0; n < 600; n++) begin
      opc_pool[5] = 8'($urandom);
      req_valid   = ($urandom_range(0, 9) < 7);
      req_instr   = {opc_pool[$urandom_range(0, 5)], 24'($urandom)};
      req_tid     = TW'($urandom_range(0, NTHR - 1));
      req_addr    = 32'h100 + ($urandom_range(0, 3) << 3) + $urandom_range(0, 7);
      resp_ready  = ($urandom_range(0, 9) < 7);
      snoop_valid = ($urandom_range(0, 99) < 15);
      snoop_addr  = 32'h100 + ($urandom_range(0, 3) << 3) + $urandom_range(0, 7);
      flush_valid = ($urandom_range(0, 99) < 10);
      flush_tid   = TW'($urandom_range(0, NTHR - 1));
      #1;
      m_ready = !e_rv || resp_ready;
      check($sformatf("rnd%0d req_ready", n), req_ready, m_ready);
      model_edge(m_ready);
      tick();
      check($sformatf("rnd%0d resp_valid", n), resp_valid, e_rv);
      if (e_rv) begin
        check($sformatf("rnd%0d resp_op", n), resp_op, e_op);
        check($sformatf("rnd%0d resp_tid", n), resp_tid, e_tid);
        check($sformatf("rnd%0d resp_sc_ok", n), resp_sc_ok, e_ok);
      end
      check($sformatf("rnd%0d rsv_valid", n), rsv_valid, model_rsv_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llsc_reservation_unit.md
LLSC_RESERVATION_UNIT -- requirements
Module: llsc_reservation_unit

Interface
REQ-001 The parameter ADDR_W SHALL default to 32 and SHALL give the address width.
REQ-002 The parameter NTHR SHALL default to 2 and SHALL give the number of hardware threads, one reservation each.
REQ-003 The parameter GRAN_LOG2 SHALL default to 3 and SHALL give log2 of the reservation granule in bytes.
REQ-004 The parameter TIMEOUT SHALL default to 255 and SHALL give the reservation lifetime in cycles (see REQ-025).
REQ-005 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both valid and ready are high.
- req_instr  in  32  raw instruction word.
- req_tid  in  TW  thread id, where TW = max(1, $clog2(NTHR)).
- req_addr  in  ADDR_W  effective address.
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer accepts the response.
- resp_tid  out  TW  thread id of the response.
- resp_op  out  2  decoded op: ATOMIC_LL, ATOMIC_SC or INVALID_OP_2B.
- resp_sc_ok  out  1  SC succeeded; 0 for all non-SC responses.
- snoop_valid  in  1  store or invalidation observed.
- snoop_addr  in  ADDR_W  address of the snooped store or invalidation.
- flush_valid  in  1  exception or ERTN on thread flush_tid.
- flush_tid  in  TW  thread to flush.
- rsv_valid  out  NTHR  per-thread reservation-held flags.

Function
REQ-006 Decode SHALL look at instr[31:24] only: 0x20 and 0x22 SHALL decode as ATOMIC_LL, 0x21 and 0x23 SHALL decode as ATOMIC_SC, and every other value SHALL decode as INVALID_OP_2B.
REQ-007 The block SHALL hold one output register; req_ready SHALL equal !resp_valid || resp_ready.
REQ-008 An accepted request SHALL produce resp_valid on the next cycle (1-cycle latency); resp_* SHALL hold stable while resp_valid && !resp_ready.
REQ-009 resp_valid SHALL clear after a handshake when no new request is accepted in the same cycle.
REQ-010 An accepted LL SHALL set rsv_valid[tid] and store rsv_gran[tid] = req_addr[ADDR_W-1:GRAN_LOG2].
REQ-011 An accepted SC SHALL set resp_sc_ok = rsv_valid[tid] && (rsv_gran[tid] == req granule) && !(same-cycle snoop hit on that granule) && !(same-cycle flush of tid).
REQ-012 Every accepted SC SHALL clear rsv_valid[tid], whether it succeeds or fails.
REQ-013 An INVALID request SHALL be accepted, SHALL respond with resp_op = INVALID_OP_2B and resp_sc_ok = 0, and SHALL NOT change reservation state.
REQ-014 snoop_valid SHALL clear rsv_valid[i] for every thread i whose granule matches the snoop_addr granule, including threads not issuing a request.
REQ-015 flush_valid SHALL clear rsv_valid[flush_tid].
REQ-016 Snoop and flush SHALL take effect regardless of req_ready or resp_ready.
REQ-017 On an LL and a snoop hit to the same granule in the same cycle, the LL SHALL win and the reservation SHALL be set (the snoop is ordered before the LL).
REQ-018 On an LL and a flush of the same tid in the same cycle, the flush SHALL win and no reservation SHALL be set; the LL SHALL still respond.
REQ-019 An LL to a thread that already holds a reservation SHALL overwrite its granule.
REQ-020 A request with req_tid >= NTHR SHALL respond as INVALID_OP_2B and SHALL NOT change reservation state.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously clear rsv_valid, resp_valid, resp_sc_ok and all timeout counters.
REQ-022 Asserting rst_n low SHALL set resp_op to INVALID_OP_2B and resp_tid to 0.
REQ-023 A response pending when reset asserts SHALL be dropped.
REQ-024 After reset, req_ready SHALL be 1.

Configuration
REQ-025 With LLSC_TIMEOUT_EN defined, each thread SHALL have a counter of $clog2(TIMEOUT+1) bits that loads 0 on LL and increments each cycle while rsv_valid[i] is set; when the counter equals TIMEOUT, rsv_valid[i] SHALL clear on the next edge.
REQ-026 Without LLSC_TIMEOUT_EN, no counters SHALL exist and a reservation SHALL persist until an SC, a snoop hit, a flush or reset.

Structure
REQ-027 The ATOMIC_LL, ATOMIC_SC and INVALID_OP_2B encodings SHALL come from the shared defs.sv and SHALL NOT be redefined locally.
REQ-028 The opcode-byte constants (0x20 to 0x23) SHALL be added to defs.sv.
REQ-029 Decode SHALL be implemented as the combinational sub-module llsc_decode (instr in, op out), instantiated once.

Verification
REQ-030 LL tid0 at 0x1000, then SC tid0 at 0x1004 -> SC response has resp_sc_ok=1 (same 8-byte granule), then rsv_valid[0]=0.
REQ-031 LL tid1 at 0x2000, snoop at 0x2007, then SC tid1 at 0x2000 -> resp_sc_ok=0; rsv_valid[0] is unaffected by the snoop.
REQ-032 Same cycle: LL tid0 at 0x3000 together with a snoop at 0x3000 -> rsv_valid[0]=1 next cycle; LL tid0 together with flush tid0 -> rsv_valid[0]=0.
REQ-033 resp_ready held 0 for 3 cycles after an LL -> req_ready=0 and resp_* stable for those cycles, then a handshake, then a second request's response arrives 1 cycle after acceptance.
REQ-034 instr[31:24]=0x28 -> resp_op=INVALID_OP_2B, resp_sc_ok=0, rsv_valid unchanged.
REQ-035 With LLSC_TIMEOUT_EN and TIMEOUT=4: LL, idle 6 cycles, SC -> resp_sc_ok=0.
REQ-036 rst_n pulsed low mid-response -> resp_valid=0 and rsv_valid=0 immediately, without waiting for a clock edge.
